cone_err_monitor: RTL

- Downstream observer for one extracted logic cone (9 inputs, 1 output) in the SEE error-analysis flow.
- Each cycle the stimulus side applies a 9-bit vector to a golden and a fault-injected copy of the cone; this block samples both outputs.
- It compares them over a campaign of N vectors, counts mismatches and captures the first failing vector.
- It reports results through a valid/ready handshake.

---
 rtl/cone_err_monitor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cone_err_monitor.sv
// cone_err_monitor: compares a golden and a fault-injected cone output over an N-vector campaign; optional mismatch log FIFO when CONE_ERR_LOG_EN is defined
module cone_err_monitor #(
  parameter int VEC_W = 9,
  parameter int IDX_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_vec,
  input  logic             vec_valid,
  input  logic [VEC_W-1:0] vec_in,
  input  logic             gold_o,
  input  logic             fault_o,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_seen,
  output logic [IDX_W-1:0] first_err_idx,
`ifdef CONE_ERR_LOG_EN
  output logic                   log_valid,
  output logic [IDX_W+VEC_W-1:0] log_data,
  input  logic                   log_pop,
  output logic                   log_ovf,
`endif
  output logic [VEC_W-1:0] first_err_vec
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;
  state_t state_q;
  logic [IDX_W-1:0] num_q, idx_q, s1_idx_q;
  logic [VEC_W-1:0] s1_vec_q;
  logic s1_valid_q, s1_gold_q, s1_fault_q;
  logic launch, accept, mism;
  assign launch = (state_q == IDLE) && start;
  assign accept = (state_q == RUN) && vec_valid;
  assign mism = s1_valid_q && (s1_gold_q != s1_fault_q);
  // control FSM, stage-1 capture and stage-2 mismatch accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy <= 1'b0;
      res_valid <= 1'b0;
      num_q <= '0;
      idx_q <= '0;
      s1_idx_q <= '0;
      s1_vec_q <= '0;
      s1_valid_q <= 1'b0;
      s1_gold_q <= 1'b0;
      s1_fault_q <= 1'b0;
      err_cnt <= '0;
      err_seen <= 1'b0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_vec_q <= vec_in;
        s1_gold_q <= gold_o;
        s1_fault_q <= fault_o;
        s1_idx_q <= idx_q;
        idx_q <= idx_q + IDX_W'(1);
      end
      if (launch) begin
        num_q <= num_vec;
        idx_q <= '0;
        err_cnt <= '0;
        err_seen <= 1'b0;
        first_err_idx <= '0;
        first_err_vec <= '0;
      end else if (mism) begin
        err_cnt <= (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
        err_seen <= 1'b1;
        if (!err_seen) begin
          first_err_idx <= s1_idx_q;
          first_err_vec <= s1_vec_q;
        end
      end
      case (state_q)
        IDLE: if (start) begin
          state_q <= (num_vec == '0) ? REPORT : RUN;
          busy <= (num_vec != '0);
          res_valid <= (num_vec == '0);
        end
        RUN: if (accept && idx_q == num_q - IDX_W'(1)) state_q <= DRAIN;
        DRAIN: begin
          state_q <= REPORT;
          busy <= 1'b0;
          res_valid <= 1'b1;
        end
        REPORT: if (res_ready) begin
          state_q <= IDLE;
          res_valid <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef CONE_ERR_LOG_EN
  logic [IDX_W+VEC_W-1:0] log_mem_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] cnt_q;
  logic pop, push_ok;
  assign log_valid = (cnt_q != 3'd0);
  assign pop = log_pop && log_valid;
  assign push_ok = mism && ((cnt_q != 3'd4) || pop);
  assign log_data = log_mem_q[rd_q];
  // mismatch log: when full, a simultaneous pop frees the head slot that the push reuses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) log_mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      log_ovf <= 1'b0;
    end else if (launch) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      log_ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        log_mem_q[wr_q] <= {s1_idx_q, s1_vec_q};
        wr_q <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_q + 3'(push_ok) - 3'(pop);
      if (mism && !push_ok) log_ovf <= 1'b1;
    end
  end
`endif
endmodule
